// File: rtl/cpu_mc.sv
// cpu_mc: multi-cycle 16-bit-instruction core with a DW-bit datapath and an AW-bit PC.
// Sequences FETCH/DECODE/EXEC/MEM/WB. Instruction and data memories use req/ready
// handshakes, so wait states are allowed.
// Optional feature: define CPU_MUL_EN to make opcode C a multiply (rd = low DW bits
// of rs*rt). When it is undefined, opcode C is a NOP.
// Ports:
//   clk, reset                   rising-edge clock; asynchronous active-high reset
//   imem_req/addr/rdata/ready    instruction fetch handshake (addr = PC)
//   dmem_req/we/addr/wdata/
//   dmem_rdata/ready             data load/store handshake (addr = low AW bits of Rs)
//   PC, FLAGS {N,Z,C,V}, halted  status outputs
module cpu_mc #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [15:0]   imem_rdata,
  input  logic          imem_ready,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ready,
  output logic [AW-1:0] PC,
  output logic [3:0]    FLAGS,
  output logic          halted
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t        state, state_nx;
  logic [AW-1:0] pc;
  logic [15:0]   ir;
  logic [DW-1:0] a, b, res;
  logic [3:0]    flags;
  logic [DW-1:0] regs [16];

  logic [3:0] op, rd, rs, rt;
  logic [7:0] imm8;

  assign op   = ir[15:12];
  assign rd   = ir[11:8];
  assign rs   = ir[7:4];
  assign rt   = ir[3:0];
  assign imm8 = ir[7:0];

  logic [DW-1:0] alu_res;
  logic          alu_c, alu_v, alu_upd, br_taken;
  logic [DW:0]   sum, diff;
`ifdef CPU_MUL_EN
  logic [2*DW-1:0] prod;
`endif

  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    diff    = {1'b0, a} - {1'b0, b};
`ifdef CPU_MUL_EN
    prod    = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
`endif
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_upd = 1'b0;
    case (op)
      4'h1: begin
        alu_res = sum[DW-1:0];
        alu_c   = sum[DW];
        alu_v   = (a[DW-1] == b[DW-1]) && (sum[DW-1] != a[DW-1]);
        alu_upd = 1'b1;
      end
      4'h2: begin
        alu_res = diff[DW-1:0];
        alu_c   = ~diff[DW];  // carry = no borrow
        alu_v   = (a[DW-1] != b[DW-1]) && (diff[DW-1] != a[DW-1]);
        alu_upd = 1'b1;
      end
      4'h3: begin alu_res = a & b; alu_upd = 1'b1; end
      4'h4: begin alu_res = a | b; alu_upd = 1'b1; end
      4'h5: begin alu_res = a ^ b; alu_upd = 1'b1; end
      4'h6: alu_res = DW'(imm8);
`ifdef CPU_MUL_EN
      4'hC: begin
        alu_res = prod[DW-1:0];
        alu_c   = |prod[2*DW-1:DW];
        alu_upd = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Branch condition uses the flags as held before the branch.
  always_comb begin
    br_taken = 1'b0;
    if (op == 4'h9) begin
      case (rd)
        4'd0:    br_taken = 1'b1;
        4'd1:    br_taken = flags[2];
        4'd2:    br_taken = ~flags[2];
        4'd3:    br_taken = flags[1];
        4'd4:    br_taken = flags[3];
        default: br_taken = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:  if (imem_ready) state_nx = S_DECODE;
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        case (op)
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: state_nx = S_WB;
`ifdef CPU_MUL_EN
          4'hC:       state_nx = S_WB;
`endif
          4'h7, 4'h8: state_nx = S_MEM;
          4'hF:       state_nx = S_HALT;
          default:    state_nx = S_FETCH;
        endcase
      end
      S_MEM:   if (dmem_ready) state_nx = (op == 4'h7) ? S_WB : S_FETCH;
      S_WB:    state_nx = S_FETCH;
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc    <= '0;
      ir    <= '0;
      a     <= '0;
      b     <= '0;
      res   <= '0;
      flags <= '0;
      for (int unsigned i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: if (imem_ready) begin
          ir <= imem_rdata;
          pc <= pc + 1'b1;
        end
        S_DECODE: begin
          a <= regs[rs];
          b <= (op == 4'h8) ? regs[rd] : regs[rt];
        end
        S_EXEC: begin
          res <= alu_res;
          if (alu_upd) flags <= {alu_res[DW-1], alu_res == '0, alu_c, alu_v};
          // pc already points past the branch; cast sign-extends imm8 to AW bits
          if (br_taken) pc <= pc + AW'($signed(imm8));
        end
        S_MEM:   if (dmem_ready && op == 4'h7) res <= dmem_rdata;
        S_WB:    if (rd != 4'd0) regs[rd] <= res;
        default: ;
      endcase
    end
  end

  // Reset leaves state at FETCH, so the request is gated by reset to drop it immediately.
  assign imem_req   = (state == S_FETCH) && !reset;
  assign imem_addr  = pc;
  assign dmem_req   = (state == S_MEM);
  assign dmem_we    = (state == S_MEM) && (op == 4'h8);
  assign dmem_addr  = (state == S_MEM) ? AW'(a) : '0;
  assign dmem_wdata = (state == S_MEM && op == 4'h8) ? b : '0;
  assign PC         = pc;
  assign FLAGS      = flags;
  assign halted     = (state == S_HALT);

endmodule

// File: tb/tb_cpu_mc.sv
// Bench for cpu_mc (DW=8, AW=8): table of ALU vectors plus hand-written programs
// for latency, wait states, branches, PC wrap, R0, halt and reset mid-fetch.
// Stores are checked against a scoreboard queue filled when each program is loaded.
module tb_cpu_mc;

  logic        clk, reset;
  logic        imem_req, imem_ready;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [7:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  PC;
  logic [3:0]  FLAGS;
  logic        halted;

  cpu_mc #(.DW(8), .AW(8)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .PC(PC), .FLAGS(FLAGS), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] prog [256];
  logic [7:0]  dmem [256];
  int iwait, dwait, hold_addr;
  int nf, nd;
  int fetch_addr [64];
  int fetch_cyc  [64];
  int dcyc [16];
  bit dstab [16];

  typedef struct {logic [7:0] addr; logic [7:0] data;} st_t;
  st_t sb [$];

  typedef struct {logic [3:0] op; logic [7:0] x; logic [7:0] y; logic [7:0] res; logic [3:0] flg;} vec_t;
  vec_t vecs [12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic exp_store(input logic [7:0] ad, input logic [7:0] da);
    st_t e;
    e.addr = ad;
    e.data = da;
    sb.push_back(e);
  endtask

  // Instruction memory responder
  initial begin
    int icnt;
    icnt = 0;
    imem_ready = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset || !imem_req) begin
        imem_ready = 1'b0;
        icnt = 0;
      end else if (int'(imem_addr) == hold_addr) begin
        imem_ready = 1'b0;
      end else if (icnt >= iwait) begin
        imem_ready = 1'b1;
        imem_rdata = prog[imem_addr];
        if (nf < 64) begin
          fetch_addr[nf] = int'(imem_addr);
          fetch_cyc[nf]  = cyc;
        end
        nf++;
        icnt = 0;
      end else begin
        imem_ready = 1'b0;
        icnt++;
      end
    end
  end

  // Data memory responder with store scoreboard
  initial begin
    int dcnt;
    logic [7:0] a0, w0;
    logic we0;
    bit stab;
    st_t e;
    dcnt = 0; stab = 1'b1; a0 = '0; w0 = '0; we0 = 1'b0;
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset || !dmem_req) begin
        dmem_ready = 1'b0;
        dcnt = 0;
      end else begin
        if (dcnt == 0) begin
          a0 = dmem_addr; w0 = dmem_wdata; we0 = dmem_we; stab = 1'b1;
        end else if (dmem_addr !== a0 || dmem_wdata !== w0 || dmem_we !== we0) begin
          stab = 1'b0;
        end
        if (dcnt >= dwait) begin
          dmem_ready = 1'b1;
          if (dmem_we) begin
            dmem[dmem_addr] = dmem_wdata;
            if (sb.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL store_extra: got addr=%0h data=%0h, required no store", dmem_addr, dmem_wdata);
            end else begin
              e = sb.pop_front();
              check("store_addr", dmem_addr, e.addr);
              check("store_data", dmem_wdata, e.data);
            end
          end else begin
            dmem_rdata = dmem[dmem_addr];
          end
          if (nd < 16) begin
            dcyc[nd]  = dcnt + 1;
            dstab[nd] = stab;
          end
          nd++;
          dcnt = 0;
        end else begin
          dmem_ready = 1'b0;
          dcnt++;
        end
      end
    end
  end

  // Hold the core in reset and clear program, data memory, logs and scoreboard.
  task automatic begin_test();
    @(negedge clk);
    #1 reset = 1'b1;
    sb.delete();
    for (int i = 0; i < 256; i++) begin
      prog[i] = 16'hF000;
      dmem[i] = 8'h00;
    end
    iwait = 0; dwait = 0; hold_addr = -1;
    nf = 0; nd = 0;
  endtask

  task automatic go();
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic run_until_halt(input int budget);
    int k;
    k = 0;
    while (!halted && k < budget) begin
      @(negedge clk);
      k++;
    end
    #1 check("halt_reached", halted, 1'b1);
  endtask

  task automatic wait_fetches(input int n, input int budget);
    int k;
    k = 0;
    while (nf < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    #1 check("fetch_count", nf >= n, 1'b1);
  endtask

  task automatic load_main();
    prog[0] = 16'h617F;  // LI  R1,7F
    prog[1] = 16'h6201;  // LI  R2,01
    prog[2] = 16'h1312;  // ADD R3,R1,R2
    prog[3] = 16'h8120;  // ST  R1,[R2]
    prog[4] = 16'h7520;  // LD  R5,[R2]
    prog[5] = 16'h8500;  // ST  R5,[R0]
    prog[6] = 16'h8310;  // ST  R3,[R1]
    prog[7] = 16'hF000;  // HALT
    exp_store(8'h01, 8'h7F);
    exp_store(8'h00, 8'h7F);
    exp_store(8'h7F, 8'h80);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap0 [7];
    int gap1 [7];
    int bseq [7];
    int nf_h;

    reset = 1'b1;
    iwait = 0; dwait = 0; hold_addr = -1; nf = 0; nd = 0;
    for (int i = 0; i < 256; i++) begin
      prog[i] = 16'hF000;
      dmem[i] = 8'h00;
    end

    vecs[0]  = '{4'h1, 8'h7F, 8'h01, 8'h80, 4'b1001};
    vecs[1]  = '{4'h1, 8'hFF, 8'h01, 8'h00, 4'b0110};
    vecs[2]  = '{4'h1, 8'h80, 8'h80, 8'h00, 4'b0111};
    vecs[3]  = '{4'h2, 8'h05, 8'h05, 8'h00, 4'b0110};
    vecs[4]  = '{4'h2, 8'h03, 8'h05, 8'hFE, 4'b1000};
    vecs[5]  = '{4'h2, 8'h80, 8'h01, 8'h7F, 4'b0011};
    vecs[6]  = '{4'h3, 8'hF0, 8'h3C, 8'h30, 4'b0000};
    vecs[7]  = '{4'h4, 8'hF0, 8'h0F, 8'hFF, 4'b1000};
    vecs[8]  = '{4'h5, 8'hAA, 8'hAA, 8'h00, 4'b0100};
    vecs[9]  = '{4'h5, 8'h12, 8'h34, 8'h26, 4'b0000};
`ifdef CPU_MUL_EN
    vecs[10] = '{4'hC, 8'h7F, 8'h7F, 8'h01, 4'b0010};
`else
    vecs[10] = '{4'hC, 8'h7F, 8'h7F, 8'h00, 4'b0000};
`endif
    vecs[11] = '{4'hA, 8'h11, 8'h22, 8'h00, 4'b0000};

    gap0 = '{4, 4, 4, 4, 5, 4, 4};
    gap1 = '{6, 6, 6, 9, 10, 9, 9};
    bseq = '{0, 1, 2, 3, 4, 7, 6};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_dmem_req", dmem_req, 1'b0);
    check("rst_dmem_we", dmem_we, 1'b0);
    check("rst_dmem_addr", dmem_addr, 8'h00);
    check("rst_dmem_wdata", dmem_wdata, 8'h00);
    check("rst_pc", PC, 8'h00);
    check("rst_flags", FLAGS, 4'h0);
    check("rst_halted", halted, 1'b0);

    // ALU table: LI R1,x; LI R2,y; op R3,R1,R2; ST R3,[R0]; HALT
    for (int i = 0; i < 12; i++) begin
      begin_test();
      prog[0] = {8'h61, vecs[i].x};
      prog[1] = {8'h62, vecs[i].y};
      prog[2] = {vecs[i].op, 12'h312};
      prog[3] = 16'h8300;
      exp_store(8'h00, vecs[i].res);
      go();
      run_until_halt(300);
      check($sformatf("vec%0d_flags", i), FLAGS, vecs[i].flg);
      check($sformatf("vec%0d_sb_left", i), sb.size(), 0);
    end

    // Zero-wait latencies, halt stickiness
    begin_test();
    load_main();
    go();
    run_until_halt(400);
    check("main_flags", FLAGS, 4'b1001);
    check("main_sb_left", sb.size(), 0);
    for (int k = 0; k < 7; k++)
      check($sformatf("lat0_instr%0d", k), fetch_cyc[k+1] - fetch_cyc[k], gap0[k]);
    nf_h = nf;
    repeat (20) @(negedge clk);
    #1;
    check("halt_no_fetch", nf, nf_h);
    check("halt_imem_req", imem_req, 1'b0);
    check("halt_sticky", halted, 1'b1);

    // Same program with imem wait 2, dmem wait 3
    begin_test();
    load_main();
    iwait = 2;
    dwait = 3;
    go();
    run_until_halt(600);
    check("wait_sb_left", sb.size(), 0);
    for (int k = 0; k < 7; k++)
      check($sformatf("latw_instr%0d", k), fetch_cyc[k+1] - fetch_cyc[k], gap1[k]);
    check("st_hold_cycles", dcyc[0], 4);
    check("st_hold_stable", dstab[0], 1'b1);
    check("ld_hold_cycles", dcyc[1], 4);

    // Branches: not-taken, cond>4 as NOP, taken forward, taken backward
    begin_test();
    prog[0] = 16'h6201;  // LI  R2,01
    prog[1] = 16'h2422;  // SUB R4,R2,R2
    prog[2] = 16'h9205;  // B !Z  (not taken)
    prog[3] = 16'h9705;  // cond 7 -> NOP
    prog[4] = 16'h9302;  // B C   -> 7
    prog[7] = 16'h91FE;  // B Z   -> 6
    go();
    run_until_halt(300);
    check("br_flags", FLAGS, 4'b0110);
    check("br_nfetch", nf, 7);
    for (int k = 0; k < 7; k++)
      check($sformatf("br_fetch%0d", k), fetch_addr[k], bseq[k]);

    // Offset 0xFF targets the branch itself
    begin_test();
    prog[0] = 16'h0000;
    prog[1] = 16'h90FF;
    go();
    wait_fetches(5, 100);
    check("self_br_a", fetch_addr[2], 1);
    check("self_br_b", fetch_addr[3], 1);

    // PC wrap 0xFF -> 0x00
    begin_test();
    prog[8'h00] = 16'h907F;
    prog[8'h80] = 16'h907E;
    prog[8'hFF] = 16'h0000;
    go();
    wait_fetches(4, 100);
    check("wrap_f1", fetch_addr[1], 8'h80);
    check("wrap_f2", fetch_addr[2], 8'hFF);
    check("wrap_f3", fetch_addr[3], 8'h00);

    // R0 writes ignored
    begin_test();
    prog[0] = 16'h6055;  // LI  R0,55
    prog[1] = 16'h1600;  // ADD R6,R0,R0
    prog[2] = 16'h8600;  // ST  R6,[R0]
    exp_store(8'h00, 8'h00);
    go();
    run_until_halt(200);
    check("r0_flags", FLAGS, 4'b0100);
    check("r0_sb_left", sb.size(), 0);

    // Reset asserted mid-fetch
    begin_test();
    prog[0] = 16'h617F;
    prog[1] = 16'h6201;
    prog[2] = 16'h1312;
    prog[3] = 16'h0000;
    hold_addr = 3;
    go();
    begin
      int k;
      k = 0;
      while (!(imem_req && PC == 8'h03) && k < 100) begin
        @(negedge clk);
        k++;
      end
    end
    #1;
    check("mid_pre_req", imem_req, 1'b1);
    check("mid_pre_flags", FLAGS, 4'b1001);
    #1 reset = 1'b1;
    #1;
    check("mid_imem_req", imem_req, 1'b0);
    check("mid_pc", PC, 8'h00);
    check("mid_flags", FLAGS, 4'h0);
    check("mid_halted", halted, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
